alu_result_buffer: RTL and testbench

//   Downstream stage of the ALU/shifter datapath. Captures each completed ALU

---
 rtl/alu_result_buffer.sv | 72 +++++++
 tb/tb_alu_result_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: {hi,lo} result FIFO between the ALU and the bus-drive logic; head shown on zhi/zlo.
// Optional head flags z_zero/z_neg are built when ALU_Z_FLAGS_EN is defined.
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [WIDTH-1:0]         alu_hi,
  input  logic [WIDTH-1:0]         alu_lo,
  output logic                     z_valid,
  input  logic                     z_ready,
  output logic [WIDTH-1:0]         zhi,
  output logic [WIDTH-1:0]         zlo,
`ifdef ALU_Z_FLAGS_EN
  output logic                     z_zero,
  output logic                     z_neg,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_hi [DEPTH];
  logic [WIDTH-1:0] mem_lo [DEPTH];
  logic push, pop;
  always_comb begin
    alu_ready = count != FULL;
    z_valid   = count != '0;
    push      = alu_valid && alu_ready;
    pop       = z_valid && z_ready;
    zhi       = z_valid ? mem_hi[rd_ptr] : '0;
    zlo       = z_valid ? mem_lo[rd_ptr] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
    end
  // storage needs no reset: outputs are masked by occupancy
  always_ff @(posedge clk)
    if (push && !flush) begin
      mem_hi[wr_ptr] <= alu_hi;
      mem_lo[wr_ptr] <= alu_lo;
    end
`ifdef ALU_Z_FLAGS_EN
  logic mem_zero [DEPTH];
  logic mem_neg  [DEPTH];
  always_ff @(posedge clk)
    if (push && !flush) begin
      mem_zero[wr_ptr] <= {alu_hi, alu_lo} == '0;
      mem_neg[wr_ptr]  <= (alu_hi != '0) ? alu_hi[WIDTH-1] : alu_lo[WIDTH-1];
    end
  always_comb begin
    z_zero = z_valid && mem_zero[rd_ptr];
    z_neg  = z_valid && mem_neg[rd_ptr];
  end
`endif
endmodule

// File: tb/tb_alu_result_buffer.sv
// tb_alu_result_buffer: directed-vector bench for alu_result_buffer (WIDTH=32, DEPTH=2).
module tb_alu_result_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n, flush, alu_valid, z_ready;
  logic alu_ready, z_valid;
  logic [WIDTH-1:0] alu_hi, alu_lo, zhi, zlo;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_Z_FLAGS_EN
  logic z_zero, z_neg;
`endif
  int vectors = 0;
  int miscompares = 0;

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .z_valid(z_valid), .z_ready(z_ready),
    .zhi(zhi), .zlo(zlo),
`ifdef ALU_Z_FLAGS_EN
    .z_zero(z_zero), .z_neg(z_neg),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    alu_valid = 1'b1;
    alu_hi = hi;
    alu_lo = lo;
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; alu_valid = 1'b0; z_ready = 1'b0;
    alu_hi = '0; alu_lo = '0;
    #3;
    check("rst_count", count, 0);
    check("rst_ready", alu_ready, 1);
    check("rst_zvalid", z_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // two shift results, consumer stalled
    push_one(0, 5 >> 3);
    check("p1_count", count, 1);
    check("p1_zvalid", z_valid, 1);
    check("p1_zlo", zlo, 0);
    push_one(0, 6 >> 1);
    check("p2_count", count, 2);
    check("p2_ready", alu_ready, 0);
    check("p2_zlo", zlo, 0);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    check("pop_zlo", zlo, 3);
    check("pop_count", count, 1);

    // asynchronous reset with one entry held
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_zvalid", z_valid, 0);
    check("arst_ready", alu_ready, 1);
    check("arst_zlo", zlo, 0);
    rst_n = 1'b1;

    // full + pop + push offered
    push_one(32'h11, 32'hA);
    push_one(32'h22, 32'hB);
    check("full_count", count, 2);
    check("full_zhi", zhi, 32'h11);
    alu_valid = 1'b1; alu_hi = 32'h33; alu_lo = 32'hC; z_ready = 1'b1;
    tick();
    alu_valid = 1'b0;
    check("fp_count", count, 1);
    check("fp_zlo", zlo, 32'hB);
    check("fp_zhi", zhi, 32'h22);
    tick();
    z_ready = 1'b0;
    check("fp_drain_count", count, 0);
    check("fp_drain_zlo", zlo, 0);

    // streaming push+pop, pointers wrap
    for (int i = 1; i <= 8; i++) begin
      alu_valid = 1'b1; alu_hi = 32'(i * 16); alu_lo = 32'(i); z_ready = 1'b1;
      tick();
      check($sformatf("stream_zlo%0d", i), zlo, 64'(i));
      check($sformatf("stream_zhi%0d", i), zhi, 64'(i * 16));
      check($sformatf("stream_count%0d", i), count, 1);
    end
    alu_valid = 1'b0;
    tick();
    z_ready = 1'b0;
    check("stream_end_count", count, 0);

    // flush overrides a simultaneous push
    push_one(0, 32'h55);
    push_one(0, 32'h66);
    check("pre_flush_count", count, 2);
    flush = 1'b1; alu_valid = 1'b1; alu_lo = 32'h77; z_ready = 1'b1;
    tick();
    flush = 1'b0; alu_valid = 1'b0; z_ready = 1'b0;
    check("flush_count", count, 0);
    check("flush_zvalid", z_valid, 0);
    check("flush_zlo", zlo, 0);
    push_one(32'hDEADBEEF, 32'h99);
    check("post_flush_zlo", zlo, 32'h99);
    check("post_flush_zhi", zhi, 32'hDEADBEEF);
    check("post_flush_count", count, 1);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    check("post_flush_pop", count, 0);

`ifdef ALU_Z_FLAGS_EN
    push_one(0, 32'h8000_0000);
    check("flag_neg", z_neg, 1);
    check("flag_nz", z_zero, 0);
    push_one(0, 0);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    check("flag_zero", z_zero, 1);
    check("flag_zero_neg", z_neg, 0);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
    check("flag_empty", z_zero, 0);
    push_one(32'h8000_0000, 1);
    check("flag_hi_neg", z_neg, 1);
    z_ready = 1'b1;
    tick();
    z_ready = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
